// File: rtl/decoder_pkg.sv
// Shared types and helpers for the sequenced one-hot decoder.
package decoder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Widest select supported by the shared onehot helper.
  localparam int MAX_N    = 8;
  localparam int MAX_OUTS = 2 ** MAX_N;

  function automatic logic [MAX_OUTS-1:0] onehot(input logic [MAX_N-1:0] idx, input int n);
    onehot = '0;
    if (int'(idx) < (2 ** n)) onehot[idx] = 1'b1;
  endfunction

  // Dwell counter width: clog2(dwell), never narrower than one bit.
  function automatic int dwell_w(input int dwell);
    dwell_w = (dwell <= 2) ? 1 : $clog2(dwell);
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// Pure combinational N-to-2^N binary to one-hot decoder.
module onehot_dec
  import decoder_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]      sel,
  output logic [2**N-1:0]   dec
);

  localparam int OUTS = 2 ** N;

  assign dec = OUTS'(onehot(MAX_N'(sel), N));

endmodule

// File: rtl/decoder_seq.sv
// Registered N-to-2^N decoder with a valid/ready load port, enable gate
// and a self-timed scan mode that walks every output line in turn.
module decoder_seq
  import decoder_pkg::*;
#(
  parameter int N     = 4,
  parameter int DWELL = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      in,
  input  logic              start,
  output logic [2**N-1:0]   out,
  output logic              out_valid,
  output logic [N-1:0]      idx,
  output logic              busy,
  output logic              done
);

  localparam int                  OUTS     = 2 ** N;
  localparam int                  DWELL_W  = dwell_w(DWELL);
  localparam logic [DWELL_W-1:0]  LAST_CNT = DWELL_W'(DWELL - 1);
  localparam logic [N-1:0]        LAST_IDX = N'(OUTS - 1);

  state_t              state;
  logic [DWELL_W-1:0]  cnt;
  logic                armed;
  logic [N-1:0]        idx_next;
  logic [OUTS-1:0]     dec_next;
  logic                load;
  logic                launch;
  logic                line_end;
  logic                scan_end;

  assign in_ready = !busy && !mode;
  assign load     = in_valid && in_ready;
  assign launch   = (state == IDLE) && mode && start;
  assign line_end = (state == SCAN) && (cnt == LAST_CNT);
  assign scan_end = line_end && (idx == LAST_IDX);

  always_comb begin
    idx_next = idx;
    if (load)
      idx_next = in;
    else if (launch)
      idx_next = '0;
    else if (line_end && !scan_end)
      idx_next = idx + 1'b1;
  end

  onehot_dec #(.N(N)) u_dec (
    .sel (idx_next),
    .dec (dec_next)
  );

  // armed marks that idx holds a loaded value worth re-driving when en
  // returns; after reset or a finished scan the output stays dark until a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      armed     <= 1'b0;
      idx       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      idx       <= idx_next;
      out_valid <= load;
      done      <= scan_end;
      case (state)
        IDLE: begin
          if (load) armed <= 1'b1;
          if (launch) begin
            state <= SCAN;
            busy  <= 1'b1;
            cnt   <= '0;
            armed <= 1'b0;
          end
          out <= (en && (load || armed || launch)) ? dec_next : '0;
        end
        SCAN: begin
          if (line_end) begin
            cnt <= '0;
            if (scan_end) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
          out <= (en && !scan_end) ? dec_next : '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
